// File: rtl/dac_waveform_player_if.sv
// AXI-stream style bundles used by the waveform player: a plain stream with
// backpressure and a per-channel parallel stream for the DAC lanes.
interface Axis_If #(
   parameter int DWIDTH = 32
);
   logic [DWIDTH-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;

   modport Master_Full     (output data, valid, last, input ready);
   modport Slave_Full      (input data, valid, last, output ready);
   modport Master_Realtime (output data, valid, last);
   modport Slave_Realtime  (input data, valid);
endinterface

interface Axis_Parallel_If #(
   parameter int CHANNELS = 8,
   parameter int DWIDTH   = 256
);
   logic [CHANNELS-1:0][DWIDTH-1:0] data;
   logic [CHANNELS-1:0]             valid;
   logic [CHANNELS-1:0]             ready;
   logic [CHANNELS-1:0]             last;

   modport Master_Realtime (output data, valid, last);
   modport Slave_Realtime  (input data, valid, last);
endinterface

// File: rtl/dac_waveform_player.sv
// Multi-channel DAC waveform player: loads one frame per channel from a DMA
// stream, then replays all channels in lockstep for N bursts or continuously.
module dac_waveform_player #(
   parameter int CHANNELS         = 8,
   parameter int BUFFER_DEPTH     = 2048,
   parameter int PARALLEL_SAMPLES = 16,
   parameter int SAMPLE_WIDTH     = 16,
   parameter int BURST_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   Axis_If.Slave_Full               dma_data_in,
   Axis_Parallel_If.Master_Realtime dac_data_out,
   Axis_If.Slave_Realtime           config_in,
   Axis_If.Master_Realtime          player_status
);
   localparam int DW = PARALLEL_SAMPLES * SAMPLE_WIDTH;
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int LW = $clog2(BUFFER_DEPTH) + 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_START = 2'd2;
   localparam logic [1:0] OP_STOP  = 2'd3;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2, PLAY = 2'd3} state_t;

   state_t                          state, state_next;
   logic [LW-1:0]                   len [CHANNELS];
   logic [LW-1:0]                   period;
   logic [CW-1:0]                   chan;
   logic                            overflow;
   logic [AW-1:0]                   addr;
   logic [BURST_WIDTH-1:0]          burst_n, burst_cnt;
   logic [15:0]                     done_cnt;
   logic                            out_valid;
   logic [CHANNELS-1:0][DW-1:0]     out_data;
   logic [DW-1:0]                   mem [CHANNELS][BUFFER_DEPTH];

   logic [1:0] opcode;
   logic       load_cmd, start_cmd, stop_load, beat, wr_en, frame_end, wrap, last_read;

   // Handshake: a DMA beat transfers on valid && ready; ready is high only in LOAD.
   always_comb begin
      opcode    = config_in.valid ? config_in.data[1:0] : 2'd0;
      load_cmd  = (state == IDLE || state == READY) && opcode == OP_LOAD;
      start_cmd = (state == READY) && opcode == OP_START && period != '0;
      stop_load = (state == LOAD) && opcode == OP_STOP;
      beat      = (state == LOAD) && !stop_load && dma_data_in.valid;
      wr_en     = beat && (len[chan] < LW'(BUFFER_DEPTH));
      frame_end = beat && dma_data_in.last;
      wrap      = (state == PLAY) && ((LW'(addr) + LW'(1)) == period);
      last_read = wrap && burst_n != '0 && (burst_cnt + BURST_WIDTH'(1)) == burst_n;
   end

   // The replay period is the longest loaded frame; shorter channels pad with zeros.
   always_comb begin
      period = '0;
      for (int c = 0; c < CHANNELS; c++)
         if (len[c] > period) period = len[c];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (load_cmd) state_next = LOAD;
         LOAD: begin
            if (stop_load) state_next = IDLE;
            else if (frame_end && chan == CW'(CHANNELS - 1)) state_next = READY;
         end
         READY: begin
            if (load_cmd) state_next = LOAD;
            else if (start_cmd) state_next = PLAY;
         end
         PLAY:  if (opcode == OP_STOP || last_read) state_next = READY;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chan      <= '0;
         overflow  <= 1'b0;
         addr      <= '0;
         burst_n   <= '0;
         burst_cnt <= '0;
         done_cnt  <= '0;
         for (int c = 0; c < CHANNELS; c++) len[c] <= '0;
      end else begin
         if (load_cmd || stop_load)
            for (int c = 0; c < CHANNELS; c++) len[c] <= '0;
         if (load_cmd) begin
            chan     <= '0;
            overflow <= 1'b0;
         end
         if (wr_en) len[chan] <= len[chan] + LW'(1);
         if (beat && !wr_en) overflow <= 1'b1;
         if (frame_end) chan <= chan + CW'(1);
         if (start_cmd) begin
            burst_n   <= config_in.data[BURST_WIDTH+1:2];
            addr      <= '0;
            burst_cnt <= '0;
            done_cnt  <= '0;
         end
         if (state == PLAY) begin
            addr <= wrap ? '0 : addr + AW'(1);
            if (wrap) begin
               burst_cnt <= burst_cnt + BURST_WIDTH'(1);
               if (done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[chan][len[chan][AW-1:0]] <= dma_data_in.data;
   end

   // One-cycle read pipeline; the beat for the last issued read trails into READY.
   always_ff @(posedge clk) begin
      if (reset || state != PLAY) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b1;
         for (int c = 0; c < CHANNELS; c++)
            out_data[c] <= (LW'(addr) < len[c]) ? mem[c][addr] : '0;
      end
   end

   always_comb begin
      dma_data_in.ready   = (state == LOAD);
      dac_data_out.valid  = {CHANNELS{out_valid}};
      dac_data_out.data   = out_data;
      dac_data_out.last   = '0;
      player_status.valid = 1'b1;
      player_status.last  = 1'b0;
      player_status.data  = {done_cnt, 13'd0, overflow, state};
   end
endmodule

// File: tb/tb_dac_waveform_player.sv
// Bench for dac_waveform_player: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dac_waveform_player;
   localparam int CH    = 4;
   localparam int DEPTH = 16;
   localparam int PS    = 2;
   localparam int SW    = 8;
   localparam int DW    = PS * SW;
   localparam int BW    = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   Axis_If #(.DWIDTH(DW))                     dma_if ();
   Axis_Parallel_If #(.CHANNELS(CH), .DWIDTH(DW)) dac_if ();
   Axis_If #(.DWIDTH(BW + 2))                 cfg_if ();
   Axis_If #(.DWIDTH(32))                     st_if ();

   dac_waveform_player #(
      .CHANNELS(CH), .BUFFER_DEPTH(DEPTH), .PARALLEL_SAMPLES(PS),
      .SAMPLE_WIDTH(SW), .BURST_WIDTH(BW)
   ) dut (
      .clk(clk), .reset(reset), .dma_data_in(dma_if), .dac_data_out(dac_if),
      .config_in(cfg_if), .player_status(st_if)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: per-channel queues of loaded words, replay position, burst count.
   logic [DW-1:0]      m_q [CH][$];
   int                 m_state = 0, m_chan = 0, m_n = 0, m_pos = 0, m_l = 0, m_bursts = 0;
   bit                 m_ovf = 1'b0;
   logic               m_valid = 1'b0;
   logic [CH*DW-1:0]   m_data = '0;

   always @(posedge clk) begin : model
      int op, l;
      op = (cfg_if.valid === 1'b1) ? int'(cfg_if.data[1:0]) : 0;
      if (reset) begin
         m_state = 0; m_chan = 0; m_pos = 0; m_ovf = 1'b0; m_bursts = 0;
         m_valid = 1'b0; m_data = '0;
         for (int c = 0; c < CH; c++) m_q[c].delete();
      end else begin
         m_valid = (m_state == 3);
         m_data  = '0;
         if (m_state == 3)
            for (int c = 0; c < CH; c++)
               if (m_pos < m_q[c].size()) m_data[c*DW +: DW] = m_q[c][m_pos];
         case (m_state)
            0, 2: begin
               if (op == 1) begin
                  for (int c = 0; c < CH; c++) m_q[c].delete();
                  m_chan = 0; m_ovf = 1'b0; m_state = 1;
               end else if (m_state == 2 && op == 2) begin
                  l = 0;
                  for (int c = 0; c < CH; c++) if (m_q[c].size() > l) l = m_q[c].size();
                  if (l > 0) begin
                     m_l = l; m_n = int'(cfg_if.data[BW+1:2]); m_pos = 0; m_bursts = 0; m_state = 3;
                  end
               end
            end
            1: begin
               if (op == 3) begin
                  for (int c = 0; c < CH; c++) m_q[c].delete();
                  m_state = 0;
               end else if (dma_if.valid === 1'b1) begin
                  if (m_q[m_chan].size() < DEPTH) m_q[m_chan].push_back(dma_if.data);
                  else m_ovf = 1'b1;
                  if (dma_if.last === 1'b1) begin
                     m_chan++;
                     if (m_chan == CH) m_state = 2;
                  end
               end
            end
            default: begin
               m_pos++;
               if (m_pos == m_l) begin
                  m_pos = 0;
                  if (m_bursts < 65535) m_bursts++;
               end
               if (op == 3 || (m_n != 0 && m_pos == 0 && m_bursts == m_n)) m_state = 2;
            end
         endcase
      end
   end

   // Compare process: all observable outputs against the model every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] st_exp;
         st_exp = {m_bursts[15:0], 13'd0, m_ovf, m_state[1:0]};
         check("dac_valid", 64'(dac_if.valid), 64'({CH{m_valid}}));
         check("dac_data", dac_if.data, m_data);
         check("dac_last", 64'(dac_if.last), 64'(0));
         check("status", 64'(st_if.data), 64'(st_exp));
         check("dma_ready", 64'(dma_if.ready), 64'(m_state == 1));
      end
   end

   logic [CH*DW-1:0] cap_data [$];
   int               cap_cyc  [$];
   always @(negedge clk) begin
      if (dac_if.valid[0] === 1'b1) begin
         cap_data.push_back(dac_if.data);
         cap_cyc.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] beat_word(input int i, input int c);
      logic [CH*DW-1:0] w;
      w = (i < cap_data.size()) ? cap_data[i] : 'x;
      return w[c*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cfg(input int op, input int n);
      cfg_if.valid = 1'b1;
      cfg_if.data  = {BW'(n), 2'(op)};
      tick();
      cfg_if.valid = 1'b0;
      cfg_if.data  = '0;
   endtask

   task automatic send_word(input logic [DW-1:0] w, input logic last);
      dma_if.valid = 1'b1;
      dma_if.data  = w;
      dma_if.last  = last;
      tick();
      dma_if.valid = 1'b0;
      dma_if.data  = '0;
      dma_if.last  = 1'b0;
   endtask

   // Word k of channel c is {0xC0+c, k}, so every beat names its origin.
   task automatic load_frames(input int s0, input int s1, input int s2, input int s3);
      int sz [CH];
      sz = '{s0, s1, s2, s3};
      send_cfg(1, 0);
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < sz[c]; k++)
            send_word({8'(8'hC0 + c), 8'(k)}, k == sz[c] - 1);
      tick();
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int n;
      n = 0;
      while (m_state != s && n < budget) begin
         tick();
         n++;
      end
      check(name, 64'(st_if.data[1:0]), 64'(s));
   endtask

   initial begin
      int t0, ts, after;
      reset = 1'b1;
      dma_if.valid = 1'b0; dma_if.data = '0; dma_if.last = 1'b0;
      cfg_if.valid = 1'b0; cfg_if.data = '0; cfg_if.last = 1'b0;
      dac_if.ready = '1;
      st_if.ready  = 1'b1;
      repeat (3) tick();
      chk_en = 1'b1;
      check("rst_status", 64'(st_if.data), 64'h0);
      check("rst_valid", 64'(dac_if.valid), 64'h0);
      check("rst_data", dac_if.data, 64'h0);
      check("rst_ready", 64'(dma_if.ready), 64'h0);
      reset = 1'b0;
      tick();

      // START in IDLE is not legal
      send_cfg(2, 1);
      tick();
      check("idle_start_ignored", 64'(st_if.data), 64'h0);

      // Four words per channel, two bursts
      load_frames(4, 4, 4, 4);
      check("a_loaded", 64'(st_if.data), 64'h2);
      cap_data.delete(); cap_cyc.delete();
      t0 = cyc;
      send_cfg(2, 2);
      wait_state(2, 40, "a_to_ready");
      repeat (3) tick();
      check("a_beats", 64'(cap_data.size()), 64'd8);
      check("a_latency", 64'(cap_cyc.size() > 0 ? cap_cyc[0] - t0 : -1), 64'd2);
      check("a_b1_c2", 64'(beat_word(1, 2)), 64'hC201);
      check("a_b4_c0", 64'(beat_word(4, 0)), 64'hC000);
      check("a_b7_c3", 64'(beat_word(7, 3)), 64'hC303);
      check("a_status", 64'(st_if.data), 64'h0002_0002);

      // Uneven frames: zero padding up to the longest
      load_frames(6, 2, 2, 2);
      cap_data.delete(); cap_cyc.delete();
      send_cfg(2, 1);
      wait_state(2, 40, "b_to_ready");
      repeat (3) tick();
      check("b_beats", 64'(cap_data.size()), 64'd6);
      check("b_b5_c0", 64'(beat_word(5, 0)), 64'hC005);
      check("b_b1_c1", 64'(beat_word(1, 1)), 64'hC101);
      check("b_b2_c1", 64'(beat_word(2, 1)), 64'h0);
      check("b_b5_c3", 64'(beat_word(5, 3)), 64'h0);
      check("b_status", 64'(st_if.data), 64'h0001_0002);

      // Overflow: DEPTH+3 words to channel 0
      load_frames(DEPTH + 3, 1, 1, 1);
      check("c_ovf_status", 64'(st_if.data), 64'h0001_0006);
      cap_data.delete(); cap_cyc.delete();
      send_cfg(2, 1);
      wait_state(2, 60, "c_to_ready");
      repeat (3) tick();
      check("c_beats", 64'(cap_data.size()), 64'd16);
      check("c_b15_c0", 64'(beat_word(15, 0)), 64'hC00F);
      check("c_b15_c1", 64'(beat_word(15, 1)), 64'h0);

      // Continuous play, LOAD ignored in PLAY, then STOP
      load_frames(4, 3, 2, 1);
      cap_data.delete(); cap_cyc.delete();
      t0 = cyc;
      send_cfg(2, 0);
      repeat (50) tick();
      send_cfg(1, 0);
      check("play_load_ignored", 64'(st_if.data[1:0]), 64'd3);
      repeat (48) tick();
      ts = cyc;
      send_cfg(3, 0);
      repeat (4) tick();
      check("e_state", 64'(st_if.data[1:0]), 64'd2);
      check("e_beats", 64'(cap_data.size()), 64'(ts - t0));
      after = 0;
      foreach (cap_cyc[i]) if (cap_cyc[i] > ts) after++;
      check("e_trailing", 64'(after), 64'd1);
      check("e_b9_c0", 64'(beat_word(9, 0)), 64'hC001);
      check("e_b11_c1", 64'(beat_word(11, 1)), 64'h0);

      // Reset mid-PLAY, START ignored until a fresh LOAD
      load_frames(2, 2, 2, 2);
      send_cfg(2, 0);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("f_rst_valid", 64'(dac_if.valid), 64'h0);
      check("f_rst_status", 64'(st_if.data), 64'h0);
      send_cfg(2, 1);
      tick();
      check("f_start_ignored", 64'(st_if.data), 64'h0);
      load_frames(2, 2, 2, 2);
      check("f_reloaded", 64'(st_if.data), 64'h2);
      cap_data.delete(); cap_cyc.delete();
      send_cfg(2, 1);
      wait_state(2, 20, "f_to_ready");
      repeat (3) tick();
      check("f_beats", 64'(cap_data.size()), 64'd2);
      check("f_b1_c3", 64'(beat_word(1, 3)), 64'hC301);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
